intc_benes_pipe: RTL and testbench

//  Parametrised, fully pipelined bidirectional Benes interconnect between buffer RAM slots and FHE

---
 rtl/intc_benes_pipe.sv | 227 ++++++++++++++++++++++
 tb/tb_intc_benes_pipe.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/intc_benes_pipe.sv
// Bidirectional pipelined Benes interconnect between RAM slots and FHE modules.
// Each direction owns a banked switch-config store; settings ride along with every beat.
module intc_benes_net #(
    parameter int DATA_WIDTH = 512,
    parameter int PORTS      = 32,
    parameter int IN_NUM     = 24,
    parameter int OUT_NUM    = 24,
    localparam int L         = $clog2(PORTS),
    localparam int STAGE_NUM = 2 * L - 1,
    localparam int STAGE_W   = $clog2(STAGE_NUM),
    localparam int HALF      = PORTS / 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  up_valid,
    output logic                  up_ready,
    input  logic                  up_bank,
    input  logic [DATA_WIDTH-1:0] up_data [IN_NUM],
    output logic                  dn_valid,
    input  logic                  dn_ready,
    output logic [DATA_WIDTH-1:0] dn_data [OUT_NUM],
    input  logic                  cfg_we,
    input  logic                  cfg_bank,
    input  logic [STAGE_W-1:0]    cfg_stage,
    input  logic [HALF-1:0]       cfg_word
);

    logic [HALF-1:0]       cfg    [2][STAGE_NUM];
    logic [STAGE_NUM:0]    vld_p;
    logic [DATA_WIDTH-1:0] line_p [STAGE_NUM+1][PORTS];
    logic [HALF-1:0]       word_p [STAGE_NUM][STAGE_NUM];
    logic [DATA_WIDTH-1:0] pad    [PORTS];
    logic [DATA_WIDTH-1:0] sw     [STAGE_NUM][PORTS];
    logic [DATA_WIDTH-1:0] route  [STAGE_NUM][PORTS];
    logic                  advance;

    // Source line feeding output line p of the inter-stage wiring after stage s.
    // First half un-shuffles (rotate-right destination => rotate-left source),
    // second half shuffles (rotate-left destination => rotate-right source).
    function automatic int src_idx(input int s, input int p);
        int lb;
        int blk;
        int q;
        int base;
        if (s < L - 1) begin
            lb = L - s;
        end else if (s < 2 * L - 2) begin
            lb = s - L + 3;
        end else begin
            return p;
        end
        blk  = 1 << lb;
        q    = p % blk;
        base = p - q;
        if (s < L - 1) begin
            return base + (((q << 1) & (blk - 1)) | (q >> (lb - 1)));
        end
        return base + ((q >> 1) | ((q & 1) << (lb - 1)));
    endfunction

    assign advance  = !vld_p[STAGE_NUM] || dn_ready;
    assign up_ready = advance;
    assign dn_valid = vld_p[STAGE_NUM];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cfg <= '{default: '0};
        end else if (cfg_we) begin
            cfg[cfg_bank][cfg_stage] <= cfg_word;
        end
    end

    always_comb begin
        pad = '{default: '0};
        for (int p = 0; p < IN_NUM; p++) begin
            pad[p] = up_data[p];
        end
    end

    always_comb begin
        sw    = '{default: '0};
        route = '{default: '0};
        for (int s = 0; s < STAGE_NUM; s++) begin
            for (int j = 0; j < HALF; j++) begin
                if (word_p[s][s][j]) begin
                    sw[s][2*j]   = line_p[s][2*j+1];
                    sw[s][2*j+1] = line_p[s][2*j];
                end else begin
                    sw[s][2*j]   = line_p[s][2*j];
                    sw[s][2*j+1] = line_p[s][2*j+1];
                end
            end
            for (int p = 0; p < PORTS; p++) begin
                route[s][p] = sw[s][src_idx(s, p)];
            end
        end
    end

    // p0 captures payload plus the selected bank; pN+1 holds the output of switch stage N
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p  <= '0;
            line_p <= '{default: '0};
            word_p <= '{default: '0};
        end else if (advance) begin
            vld_p     <= {vld_p[STAGE_NUM-1:0], up_valid};
            line_p[0] <= pad;
            word_p[0] <= cfg[up_bank];
            for (int s = 0; s < STAGE_NUM; s++) begin
                line_p[s+1] <= route[s];
            end
            for (int s = 1; s < STAGE_NUM; s++) begin
                word_p[s] <= word_p[s-1];
            end
        end
    end

    always_comb begin
        dn_data = '{default: '0};
        for (int k = 0; k < OUT_NUM; k++) begin
            dn_data[k] = line_p[STAGE_NUM][k];
        end
    end

endmodule

module intc_benes_pipe #(
    parameter int DATA_WIDTH = 512,
    parameter int PORTS      = 32,
    parameter int SLOT_NUM   = 24,
    parameter int MODULE_NUM = 24,
    localparam int STAGE_NUM = 2 * $clog2(PORTS) - 1,
    localparam int STAGE_W   = $clog2(STAGE_NUM)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_r2m_valid,
    output logic                  o_r2m_ready,
    input  logic                  i_r2m_bank,
    input  logic [DATA_WIDTH-1:0] i_ram_outputs [SLOT_NUM],
    output logic                  o_r2m_valid,
    input  logic                  i_r2m_ready,
    output logic [DATA_WIDTH-1:0] o_module_inputs [MODULE_NUM],
    input  logic                  i_m2r_valid,
    output logic                  o_m2r_ready,
    input  logic                  i_m2r_bank,
    input  logic [DATA_WIDTH-1:0] i_module_outputs [MODULE_NUM],
    output logic                  o_m2r_valid,
    input  logic                  i_m2r_ready,
    output logic [DATA_WIDTH-1:0] o_ram_inputs [SLOT_NUM],
    input  logic                  i_cfg_we,
    input  logic                  i_cfg_dir,
    input  logic                  i_cfg_bank,
    input  logic [STAGE_W-1:0]    i_cfg_stage,
    input  logic [PORTS/2-1:0]    i_cfg_word,
    output logic                  o_cfg_err
);

    // 2L-1 is odd and >1, so the last stage index always fits in STAGE_W bits
    localparam logic [STAGE_W-1:0] STAGE_LAST = STAGE_W'(STAGE_NUM - 1);

    logic [1:0] rst_sync;
    logic       rst_sync_n;
    logic       stage_ok;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rst_sync <= '0;
        end else begin
            rst_sync <= {rst_sync[0], 1'b1};
        end
    end

    assign rst_sync_n = rst_sync[1];
    assign stage_ok   = (i_cfg_stage <= STAGE_LAST);

    always_ff @(posedge clk or negedge rst_sync_n) begin
        if (!rst_sync_n) begin
            o_cfg_err <= 1'b0;
        end else begin
            o_cfg_err <= i_cfg_we && !stage_ok;
        end
    end

    intc_benes_net #(
        .DATA_WIDTH(DATA_WIDTH),
        .PORTS     (PORTS),
        .IN_NUM    (SLOT_NUM),
        .OUT_NUM   (MODULE_NUM)
    ) u_r2m (
        .clk      (clk),
        .rst_n    (rst_sync_n),
        .up_valid (i_r2m_valid),
        .up_ready (o_r2m_ready),
        .up_bank  (i_r2m_bank),
        .up_data  (i_ram_outputs),
        .dn_valid (o_r2m_valid),
        .dn_ready (i_r2m_ready),
        .dn_data  (o_module_inputs),
        .cfg_we   (i_cfg_we && stage_ok && !i_cfg_dir),
        .cfg_bank (i_cfg_bank),
        .cfg_stage(i_cfg_stage),
        .cfg_word (i_cfg_word)
    );

    intc_benes_net #(
        .DATA_WIDTH(DATA_WIDTH),
        .PORTS     (PORTS),
        .IN_NUM    (MODULE_NUM),
        .OUT_NUM   (SLOT_NUM)
    ) u_m2r (
        .clk      (clk),
        .rst_n    (rst_sync_n),
        .up_valid (i_m2r_valid),
        .up_ready (o_m2r_ready),
        .up_bank  (i_m2r_bank),
        .up_data  (i_module_outputs),
        .dn_valid (o_m2r_valid),
        .dn_ready (i_m2r_ready),
        .dn_data  (o_ram_inputs),
        .cfg_we   (i_cfg_we && stage_ok && i_cfg_dir),
        .cfg_bank (i_cfg_bank),
        .cfg_stage(i_cfg_stage),
        .cfg_word (i_cfg_word)
    );

endmodule

// File: tb/tb_intc_benes_pipe.sv
// Directed bench for intc_benes_pipe at N=32 with 24 slots/modules and narrow lines.
// Beat line k carries tag*64+k so routing, ordering and staleness are all visible.
module tb_intc_benes_pipe;

    localparam int DW = 16;
    localparam int N  = 32;
    localparam int NS = 24;
    localparam int NM = 24;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          i_r2m_valid, o_r2m_ready, i_r2m_bank, o_r2m_valid, i_r2m_ready;
    logic          i_m2r_valid, o_m2r_ready, i_m2r_bank, o_m2r_valid, i_m2r_ready;
    logic [DW-1:0] r2m_data [NS];
    logic [DW-1:0] r2m_out  [NM];
    logic [DW-1:0] m2r_data [NM];
    logic [DW-1:0] m2r_out  [NS];
    logic          i_cfg_we, i_cfg_dir, i_cfg_bank, o_cfg_err;
    logic [3:0]    i_cfg_stage;
    logic [15:0]   i_cfg_word;

    int checks   = 0;
    int failures = 0;

    logic [DW-1:0] got [24];
    int            lat;

    typedef struct {
        bit          dir;
        int          stage;
        logic [15:0] word;
        int          la;
        int          lb;
    } vec_t;

    vec_t vecs [10];

    always #5 clk = ~clk;

    intc_benes_pipe #(
        .DATA_WIDTH(DW),
        .PORTS     (N),
        .SLOT_NUM  (NS),
        .MODULE_NUM(NM)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .i_r2m_valid     (i_r2m_valid),
        .o_r2m_ready     (o_r2m_ready),
        .i_r2m_bank      (i_r2m_bank),
        .i_ram_outputs   (r2m_data),
        .o_r2m_valid     (o_r2m_valid),
        .i_r2m_ready     (i_r2m_ready),
        .o_module_inputs (r2m_out),
        .i_m2r_valid     (i_m2r_valid),
        .o_m2r_ready     (o_m2r_ready),
        .i_m2r_bank      (i_m2r_bank),
        .i_module_outputs(m2r_data),
        .o_m2r_valid     (o_m2r_valid),
        .i_m2r_ready     (i_m2r_ready),
        .o_ram_inputs    (m2r_out),
        .i_cfg_we        (i_cfg_we),
        .i_cfg_dir       (i_cfg_dir),
        .i_cfg_bank      (i_cfg_bank),
        .i_cfg_stage     (i_cfg_stage),
        .i_cfg_word      (i_cfg_word),
        .o_cfg_err       (o_cfg_err)
    );

    task automatic check(input bit ok, input string name, input int act, input int req);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    // Expected line k: identity, except lines la/lb exchanged; line >=24 enters as zero.
    function automatic int exp_line(input int tag, input int la, input int lb, input int k);
        if (la != lb) begin
            if (k == la) return (lb < 24) ? tag * 64 + lb : 0;
            if (k == lb) return tag * 64 + la;
        end
        return tag * 64 + k;
    endfunction

    task automatic check_got(input string name, input int tag, input int la, input int lb);
        int bad;
        bad = -1;
        for (int k = 0; k < 24; k++) begin
            if (bad < 0 && got[k] !== DW'(exp_line(tag, la, lb, k))) bad = k;
        end
        if (bad < 0) check(1'b1, name, 0, 0);
        else check(1'b0, $sformatf("%s line%0d", name, bad), int'(got[bad]), exp_line(tag, la, lb, bad));
    endtask

    task automatic load(input bit dir, input int tag);
        for (int k = 0; k < 24; k++) begin
            if (dir) m2r_data[k] = DW'(tag * 64 + k);
            else     r2m_data[k] = DW'(tag * 64 + k);
        end
    endtask

    task automatic cfg_write(input bit dir, input bit bank, input int stage, input logic [15:0] word);
        @(negedge clk);
        i_cfg_we = 1'b1; i_cfg_dir = dir; i_cfg_bank = bank;
        i_cfg_stage = 4'(stage); i_cfg_word = word;
        @(negedge clk);
        i_cfg_we = 1'b0;
    endtask

    task automatic wait_out(input bit dir, output int n);
        n = 0;
        while (!(dir ? o_m2r_valid : o_r2m_valid) && n < 40) begin
            @(negedge clk);
            n++;
        end
        for (int k = 0; k < 24; k++) got[k] = dir ? m2r_out[k] : r2m_out[k];
    endtask

    task automatic beat(input bit dir, input bit bank, input int tag);
        int n;
        @(negedge clk);
        load(dir, tag);
        if (dir) begin i_m2r_valid = 1'b1; i_m2r_bank = bank; end
        else     begin i_r2m_valid = 1'b1; i_r2m_bank = bank; end
        @(negedge clk);
        i_m2r_valid = 1'b0;
        i_r2m_valid = 1'b0;
        wait_out(dir, n);
        lat = n + 1;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{0, 0, 16'h0000, 0, 0};
        vecs[1] = '{0, 0, 16'h0001, 0, 1};
        vecs[2] = '{0, 8, 16'h0800, 22, 23};
        vecs[3] = '{0, 1, 16'h0001, 0, 2};
        vecs[4] = '{0, 7, 16'h0001, 0, 2};
        vecs[5] = '{0, 4, 16'h0001, 0, 16};
        vecs[6] = '{0, 4, 16'h0002, 8, 24};
        vecs[7] = '{1, 0, 16'h0001, 0, 1};
        vecs[8] = '{1, 4, 16'h0002, 8, 24};
        vecs[9] = '{0, 8, 16'h0001, 0, 1};

        rst_n = 1'b0;
        i_r2m_valid = 0; i_r2m_bank = 0; i_r2m_ready = 1;
        i_m2r_valid = 0; i_m2r_bank = 0; i_m2r_ready = 1;
        i_cfg_we = 0; i_cfg_dir = 0; i_cfg_bank = 0; i_cfg_stage = '0; i_cfg_word = '0;
        load(0, 0);
        load(1, 0);
        repeat (3) @(negedge clk);
        check(o_r2m_valid == 1'b0, "rst_r2m_valid", int'(o_r2m_valid), 0);
        check(o_m2r_valid == 1'b0, "rst_m2r_valid", int'(o_m2r_valid), 0);
        check(o_r2m_ready == 1'b1, "rst_r2m_ready", int'(o_r2m_ready), 1);
        check(o_m2r_ready == 1'b1, "rst_m2r_ready", int'(o_m2r_ready), 1);
        check(o_cfg_err == 1'b0, "rst_cfg_err", int'(o_cfg_err), 0);
        check(r2m_out[3] == '0, "rst_data", int'(r2m_out[3]), 0);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        // single-switch vectors, each restored to zero afterwards
        for (int i = 0; i < 10; i++) begin
            cfg_write(vecs[i].dir, 1'b0, vecs[i].stage, vecs[i].word);
            beat(vecs[i].dir, 1'b0, i + 1);
            check(lat == 10, $sformatf("vec%0d latency", i), lat, 10);
            check_got($sformatf("vec%0d route", i), i + 1, vecs[i].la, vecs[i].lb);
            cfg_write(vecs[i].dir, 1'b0, vecs[i].stage, 16'h0000);
        end

        // back-to-back banks with a same-cycle bank1 rewrite
        begin : t_b2b
            int n;
            cfg_write(0, 1, 0, 16'h0001);
            @(negedge clk);
            load(0, 20); i_r2m_valid = 1; i_r2m_bank = 0;
            @(negedge clk);
            load(0, 21); i_r2m_bank = 1;
            i_cfg_we = 1; i_cfg_dir = 0; i_cfg_bank = 1; i_cfg_stage = 4'd0; i_cfg_word = 16'h0000;
            @(negedge clk);
            i_r2m_valid = 0; i_cfg_we = 0;
            wait_out(0, n);
            check(n == 8, "b2b latency", n + 2, 10);
            check_got("b2b beat1", 20, 0, 0);
            @(negedge clk);
            check(o_r2m_valid == 1'b1, "b2b beat2 valid", int'(o_r2m_valid), 1);
            for (int k = 0; k < 24; k++) got[k] = r2m_out[k];
            check_got("b2b beat2", 21, 0, 1);
            beat(0, 1, 22);
            check_got("b2b beat3", 22, 0, 0);
        end

        // streaming with a 5-cycle downstream stall
        begin : t_stall
            int sent, rcv, bad;
            bit prev_stall, ready_ok, stable_ok, saw_low;
            logic [DW-1:0] prev0;
            sent = 0; rcv = 0; prev_stall = 0; ready_ok = 1; stable_ok = 1; saw_low = 0; prev0 = '0;
            for (int cyc = 0; cyc < 80 && rcv < 12; cyc++) begin
                @(negedge clk);
                i_r2m_ready = !(cyc >= 12 && cyc < 17);
                i_r2m_bank = 0;
                if (sent < 12) begin
                    i_r2m_valid = 1;
                    load(0, 70 + sent);
                end else begin
                    i_r2m_valid = 0;
                end
                #1;
                if (prev_stall && (!o_r2m_valid || r2m_out[0] !== prev0)) stable_ok = 0;
                if (o_r2m_ready !== (!o_r2m_valid || i_r2m_ready)) ready_ok = 0;
                if (!o_r2m_ready) saw_low = 1;
                if (o_r2m_valid && i_r2m_ready) begin
                    bad = -1;
                    for (int k = 0; k < 24; k++)
                        if (bad < 0 && r2m_out[k] !== DW'((70 + rcv) * 64 + k)) bad = k;
                    check(bad < 0, $sformatf("stall beat%0d", rcv),
                          (bad < 0) ? 0 : int'(r2m_out[bad]), (bad < 0) ? 0 : (70 + rcv) * 64 + bad);
                    rcv++;
                end
                prev_stall = o_r2m_valid && !i_r2m_ready;
                prev0 = r2m_out[0];
                if (i_r2m_valid && o_r2m_ready) sent++;
            end
            i_r2m_valid = 0;
            i_r2m_ready = 1;
            check(rcv == 12, "stall count", rcv, 12);
            check(stable_ok, "stall hold", int'(stable_ok), 1);
            check(ready_ok, "stall ready", int'(ready_ok), 1);
            check(saw_low, "stall ready low seen", int'(saw_low), 1);
        end

        // out-of-range config write alongside M2R traffic
        begin : t_err
            int n;
            @(negedge clk);
            check(o_cfg_err == 1'b0, "err idle", int'(o_cfg_err), 0);
            load(1, 40); i_m2r_valid = 1; i_m2r_bank = 0;
            i_cfg_we = 1; i_cfg_dir = 0; i_cfg_bank = 0; i_cfg_stage = 4'd9; i_cfg_word = 16'hFFFF;
            @(negedge clk);
            i_m2r_valid = 0; i_cfg_we = 0;
            check(o_cfg_err == 1'b1, "err pulse", int'(o_cfg_err), 1);
            @(negedge clk);
            check(o_cfg_err == 1'b0, "err one cycle", int'(o_cfg_err), 0);
            wait_out(1, n);
            check(n == 8, "err m2r latency", n + 2, 10);
            check_got("err m2r route", 40, 0, 0);
            beat(0, 0, 41);
            check_got("err r2m cfg kept", 41, 0, 0);
        end

        // reset with beats in flight and a held output
        begin : t_rst
            int n;
            bit stale;
            cfg_write(0, 0, 0, 16'h0001);
            i_r2m_ready = 0;
            for (int b = 0; b < 4; b++) begin
                @(negedge clk);
                load(0, 50 + b); i_r2m_valid = 1; i_r2m_bank = 0;
            end
            @(negedge clk);
            i_r2m_valid = 0;
            n = 0;
            while (!o_r2m_valid && n < 40) begin @(negedge clk); n++; end
            check(o_r2m_valid == 1'b1, "rst pre full", int'(o_r2m_valid), 1);
            rst_n = 0;
            #1;
            check(o_r2m_valid == 1'b0, "rst valid drop", int'(o_r2m_valid), 0);
            check(r2m_out[1] == '0, "rst data clear", int'(r2m_out[1]), 0);
            repeat (2) @(negedge clk);
            rst_n = 1;
            i_r2m_ready = 1;
            stale = 0;
            repeat (30) begin
                @(negedge clk);
                if (o_r2m_valid) stale = 1;
            end
            check(!stale, "rst no stale", int'(stale), 0);
            beat(0, 0, 60);
            check(lat == 10, "rst post latency", lat, 10);
            check_got("rst cfg identity", 60, 0, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
